// File: rtl/butterfly_pkg.sv
// ButterFly core shared types for the load/store unit.
// Holds the access-size and LSU state encodings, the default bus timeout
// and the alignment rule shared by the LSU datapath.
package butterfly_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUS  = 2'b01,
    LSU_RESP = 2'b10
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // Size 2'b11 has no encoding and is rejected the same way as a misaligned access.
  function automatic logic lsu_is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      LSU_BYTE: bad = 1'b0;
      LSU_HALF: bad = addr_lo[0];
      LSU_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/butterfly_lsu_align.sv
// Combinational byte-lane steering for the ButterFly LSU.
// Ports:
//   st_size, st_addr_lo, st_wdata   : store request (size, byte offset, right-justified data)
//   st_wstrb, st_wdata_lanes        : byte strobes and lane-replicated store data
//   misalign                        : request is misaligned or has an illegal size
//   ld_size, ld_unsigned, ld_addr_lo: latched load attributes
//   ld_rdata                        : raw word from the data bus
//   ld_data                         : selected lane, sign- or zero-extended
module butterfly_lsu_align
  import butterfly_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_lanes,
  output logic        misalign,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_wstrb       = 4'b0000;
    st_wdata_lanes = 32'h0;
    case (st_size)
      LSU_BYTE: begin
        st_wstrb       = 4'b0001 << st_addr_lo;
        st_wdata_lanes = {4{st_wdata[7:0]}};
      end
      LSU_HALF: begin
        st_wstrb       = 4'b0011 << st_addr_lo;
        st_wdata_lanes = {2{st_wdata[15:0]}};
      end
      LSU_WORD: begin
        st_wstrb       = 4'b1111;
        st_wdata_lanes = st_wdata;
      end
      default: ;
    endcase
  end

  assign misalign = lsu_is_misaligned(st_size, st_addr_lo);

  // Shift the addressed lane down to bit 0; halves are already known aligned.
  assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_size)
      LSU_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      LSU_WORD: ld_data = ld_rdata;
      default:  ;
    endcase
  end

endmodule

// File: rtl/butterfly_lsu.sv
// ButterFly load/store unit: one request at a time from execute onto the
// word-addressed dmem valid/ready bus, with a response pulse to writeback.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   req_*                 : request handshake and attributes from execute
//   rsp_*                 : one-cycle response (load data, tag, error flags)
//   busy_o                : high while not idle (pipeline stall)
//   dmem_*                : registered data-memory bus
//
// state    | meaning
// ---------+-----------------------------------------------------
// LSU_IDLE | ready for a request
// LSU_BUS  | dmem access in flight, waiting for ready or timeout
// LSU_RESP | response pulse to writeback
module butterfly_lsu
  import butterfly_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_misalign_o,
  output logic        rsp_buserr_o,
  output logic        busy_o,
  output logic        dmem_valid_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i
);

  // The down-counter is loaded with N-1 so terminal count zero marks the N-th BUS cycle.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LOAD = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  lsu_state_e  state_q, state_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt_q;

  logic        handshake;
  logic        bus_done;
  logic        bus_timeout;

  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata_lanes;
  logic        misalign;
  logic [31:0] ld_data;

  butterfly_lsu_align u_align (
    .st_size        (req_size_i),
    .st_addr_lo     (req_addr_i[1:0]),
    .st_wdata       (req_wdata_i),
    .st_wstrb       (st_wstrb),
    .st_wdata_lanes (st_wdata_lanes),
    .misalign       (misalign),
    .ld_size        (size_q),
    .ld_unsigned    (uns_q),
    .ld_addr_lo     (addr_lo_q),
    .ld_rdata       (dmem_rdata_i),
    .ld_data        (ld_data)
  );

  assign handshake   = req_valid_i & (state_q == LSU_IDLE);
  assign bus_done    = (state_q == LSU_BUS) & dmem_ready_i;
  assign bus_timeout = TO_EN & (state_q == LSU_BUS) & ~dmem_ready_i & (cnt_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      LSU_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (handshake) state_d = misalign ? LSU_RESP : LSU_BUS;
      end
      LSU_BUS: begin
        if (bus_done || bus_timeout) state_d = LSU_RESP;
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q        <= LSU_IDLE;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      addr_lo_q      <= 2'b00;
      rd_q           <= 5'd0;
      cnt_q          <= 16'd0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= 32'h0;
      rsp_rd_o       <= 5'd0;
      rsp_misalign_o <= 1'b0;
      rsp_buserr_o   <= 1'b0;
      dmem_valid_o   <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= 32'h0;
      dmem_wdata_o   <= 32'h0;
      dmem_wstrb_o   <= 4'b0000;
    end else begin
      state_q <= state_d;

      // Response fields live for the single RESP cycle only.
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= 32'h0;
      rsp_rd_o       <= 5'd0;
      rsp_misalign_o <= 1'b0;
      rsp_buserr_o   <= 1'b0;

      case (state_q)
        LSU_IDLE: begin
          if (handshake) begin
            we_q      <= req_we_i;
            size_q    <= req_size_i;
            uns_q     <= req_unsigned_i;
            addr_lo_q <= req_addr_i[1:0];
            rd_q      <= req_rd_i;
            if (misalign) begin
              rsp_valid_o    <= 1'b1;
              rsp_misalign_o <= 1'b1;
              rsp_rd_o       <= req_rd_i;
            end else begin
              dmem_valid_o <= 1'b1;
              dmem_we_o    <= req_we_i;
              dmem_addr_o  <= {req_addr_i[31:2], 2'b00};
              dmem_wstrb_o <= req_we_i ? st_wstrb : 4'b0000;
              dmem_wdata_o <= req_we_i ? st_wdata_lanes : 32'h0;
              cnt_q        <= TO_LOAD;
            end
          end
        end
        LSU_BUS: begin
          if (bus_done || bus_timeout) begin
            dmem_valid_o <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
            dmem_wstrb_o <= 4'b0000;
            rsp_valid_o  <= 1'b1;
            rsp_rd_o     <= rd_q;
            if (bus_done) begin
              rsp_rdata_o <= we_q ? 32'h0 : ld_data;
            end else begin
              rsp_buserr_o <= 1'b1;
            end
          end else if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_lsu.sv
module tb_butterfly_lsu;
  import butterfly_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_misalign, rsp_buserr, busy;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        dmem_valid, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  always #5 clk = ~clk;

  butterfly_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_rd_i       (req_rd),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_rd_o       (rsp_rd),
    .rsp_misalign_o (rsp_misalign),
    .rsp_buserr_o   (rsp_buserr),
    .busy_o         (busy),
    .dmem_valid_o   (dmem_valid),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_wstrb_o   (dmem_wstrb),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_ready_i   (dmem_ready)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] bus_rdata;
    int          waits;      // ready asserted in cycle waits+1; -1 = never
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_berr;
    int          rsp_cyc;
    int          vcnt;       // cycles dmem_valid must be high
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  vec_t sw_vec;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic bus_ok;
    int   vc;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_rd       = v.rd;
    dmem_ready   = 1'b0;
    dmem_rdata   = v.bus_rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bus_ok = 1'b1;
    vc = 0;
    for (int cyc = 1; cyc <= v.rsp_cyc; cyc++) begin
      @(negedge clk);
      dmem_ready = 1'b0;
      if (cyc == 1) chk($sformatf("v%0d busy", idx), {31'b0, busy}, 32'd1);
      if (cyc < v.rsp_cyc) begin
        if (rsp_valid || req_ready) bus_ok = 1'b0;
        if (dmem_valid) begin
          vc++;
          if (dmem_addr !== v.exp_addr || dmem_we !== v.we ||
              dmem_wstrb !== v.exp_wstrb || dmem_wdata !== v.exp_wdata) bus_ok = 1'b0;
        end
        if (cyc == v.waits + 1) dmem_ready = 1'b1;
      end else begin
        chk($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rd", idx), {27'b0, rsp_rd}, {27'b0, v.rd});
        chk($sformatf("v%0d misalign", idx), {31'b0, rsp_misalign}, {31'b0, v.exp_mis});
        chk($sformatf("v%0d buserr", idx), {31'b0, rsp_buserr}, {31'b0, v.exp_berr});
        chk($sformatf("v%0d dmem_valid_rsp", idx), {31'b0, dmem_valid}, 32'd0);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d bus_stable", idx), {31'b0, bus_ok}, 32'd1);
    chk($sformatf("v%0d valid_cycles", idx), vc, v.vcnt);
    chk($sformatf("v%0d after_rsp", idx), {29'b0, rsp_valid, req_ready, busy}, 32'b010);
  endtask

  initial begin
    //            we    size   uns   addr          wdata         rd     bus_rdata     w   exp_addr      strb     exp_wdata     exp_rdata     mis   berr  rc vc
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd3,  32'hFFFF_FFFF, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,        5'd5,  32'h1234_80FF, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2, 1};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0,        5'd6,  32'h1234_80FF, 0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 2, 1};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0,        5'd7,  32'h8001_0000, 3, 32'h0000_3000, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 5, 4};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,        5'd8,  32'h1111_1111, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h0000_BEEF, 5'd9,  32'h1111_1111, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0,        5'd10, 32'hDEAD_BEEF, -1, 32'h0000_5000, 4'b0000, 32'h0,       32'h0,        1'b0, 1'b1, 5, 4};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0,        5'd11, 32'hCAFE_F00D, 3, 32'h0000_5004, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b0, 5, 4};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'hFFFF_1234, 5'd12, 32'hFFFF_FFFF, 1, 32'h0000_6000, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b0, 3, 2};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'h0,        5'd13, 32'h8001_7FFE, 0, 32'h0000_7000, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 1'b0, 2, 1};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'h89AB_CDEF, 5'd14, 32'hFFFF_FFFF, 2, 32'h0000_8000, 4'b1111, 32'h89AB_CDEF, 32'h0,        1'b0, 1'b0, 4, 3};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_9000, 32'h0,        5'd15, 32'h1111_1111, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_A000, 32'h0,        5'd16, 32'h0000_007F, 0, 32'h0000_A000, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 2, 1};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_B000, 32'h0,        5'd17, 32'h1234_F00D, 0, 32'h0000_B000, 4'b0000, 32'h0,        32'hFFFF_F00D, 1'b0, 1'b0, 2, 1};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h0000_C000, 32'h1234_5678, 5'd18, 32'hFFFF_FFFF, 0, 32'h0000_C000, 4'b0001, 32'h7878_7878, 32'h0,        1'b0, 1'b0, 2, 1};
    sw_vec   = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 5'd20, 32'hFFFF_FFFF, 1, 32'h0000_0010, 4'b1111, 32'h0BAD_F00D, 32'h0,        1'b0, 1'b0, 3, 2};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {28'b0, req_ready, busy, dmem_valid, rsp_valid}, 32'b1000);
    chk("reset bus", {27'b0, dmem_we, dmem_wstrb} | dmem_addr | dmem_wdata, 32'h0);
    chk("reset rsp", rsp_rdata | {27'b0, rsp_rd} | {30'b0, rsp_misalign, rsp_buserr}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in cycle 2 of a stalled LW abandons the access silently.
    begin
      int rsp_seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0000_0020; req_rd = 5'd21; dmem_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid valid c1", {31'b0, dmem_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid after", {29'b0, dmem_valid, req_ready, rsp_valid}, 32'b010);
      rst_n = 1'b1;
      rsp_seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (rsp_valid || dmem_valid) rsp_seen++;
      end
      chk("rstmid no_rsp", rsp_seen, 0);
    end

    run_vec(99, sw_vec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
